dcache_controller: RTL and testbench
====================================

# dcache_controller

Direct-mapped, write-back, write-allocate data cache that sits between the pipeline's MEM stage and off-chip data memory. It answers the pipeline's load/store requests in the same cycle on a hit. On a miss it stalls the pipeline, writes back a dirty victim line and refills the line from memory over a request/acknowledge handshake. It replaces the single-cycle data memory as the MEM-stage responder.

## Interface
- LINES, 32, number of cache lines (power of two)
- LINE_W, 256, line width in bits (8 words, 32 bytes)
- ADDR_W, 32, byte address width
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- p1_req_i  in  1  pipeline access request (MemRead | MemWrite)
- p1_write_i  in  1  1 = store, 0 = load
- p1_addr_i  in  32  byte address; word-aligned
- p1_data_i  in  32  store data
- p1_data_o  out  32  load data; valid when p1_req_i=1 and p1_stall_o=0
- p1_stall_o  out  1  freeze PC/IFID/IDEX/EXMEM/MEMWB while 1
- mem_enable_o  out  1  memory request; held until mem_ack_i
- mem_write_o  out  1  1 = line write-back, 0 = line read
- mem_addr_o  out  32  line-aligned memory address (bits [4:0]=0)
- mem_data_o  out  256  write-back line data
- mem_data_i  in  256  refill line data, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse from memory

## Operation
- Address split: offset = addr[4:0], word select = addr[4:2], index = addr[9:5], tag = addr[31:10] (22 bits).
- Per-line state: valid, dirty, tag[21:0], data[255:0].
- Hit = valid[index] & (tag[index] == tag).
- FSM states are IDLE, WRITEBACK, REFILL and FILL.
- IDLE, load hit: p1_data_o = data[index] word[addr[4:2]] combinationally; p1_stall_o = 0.
- IDLE, store hit: at the clock edge the selected word is replaced by p1_data_i and dirty[index] is set; p1_stall_o = 0.
- IDLE, miss: p1_stall_o = 1 in the same cycle. If the victim is valid & dirty, the next state is WRITEBACK; otherwise it is REFILL.
- WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line. On mem_ack_i the next state is REFILL.
- REFILL: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {tag, index, 5'b0}. On mem_ack_i, mem_data_i is captured into a line buffer and the next state is FILL.
- FILL: the line is written with the buffer, the new tag, valid = 1 and dirty = 0. The next state is IDLE.
- In IDLE the access is re-evaluated and now hits. A store miss therefore completes as a store hit (allocate then write).
- p1_stall_o = 1 in every non-IDLE state.
- The pipeline holds p1_req_i, p1_write_i, p1_addr_i and p1_data_i stable while p1_stall_o = 1. The controller does not latch them, except for the tag/index it uses for the memory address.
- p1_req_i = 0 in IDLE gives no state change and p1_stall_o = 0.

## Timing
- Reset (rst_i = 0, asynchronous):
  - state = IDLE; all valid and dirty bits cleared.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
  - p1_data_o = 0, p1_stall_o = 0.
- Reset mid-miss aborts the transaction. The line being refilled stays invalid and memory sees mem_enable_o drop asynchronously.
- Hit latency: 0 cycles (combinational data, write at the edge).
- Clean miss stall: 1 (IDLE detect) + N_ack (REFILL) + 1 (FILL) cycles.
- Dirty miss adds N_ack cycles of WRITEBACK. N_ack is the number of cycles from mem_enable_o rising to mem_ack_i, at least 1.
- mem_enable_o, mem_write_o, mem_addr_o and mem_data_o are registered. They remain stable from request start until the cycle mem_ack_i is sampled.
- In WRITEBACK→REFILL, mem_enable_o stays high and mem_write_o/mem_addr_o change on the ack edge. There is no idle cycle between the two transfers.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- An index conflict with a different tag always evicts; there is no replacement choice.

## Structure
- Package dcache_pkg holds:
  - the state enum (IDLE, WRITEBACK, REFILL, FILL);
  - TAG_W = 22, IDX_W = 5, OFF_W = 5;
  - address field slice functions.
- Sub-module dcache_sram holds the valid/dirty/tag/data arrays:
  - asynchronous read;
  - synchronous write of either a full line or a single 32-bit word with dirty set;
  - asynchronous clear of valid/dirty on rst_i.
- The top level contains the FSM, hit compare, word mux and memory-side registers.

## Test plan
- Reset, then load 0x0000_0040: miss. REFILL issues mem_addr_o = 0x40 with no write-back. Memory returns a line with word0 = 0x1111_1111 after 3 cycles. Stall lasts 5 cycles, then p1_data_o = 0x1111_1111.
- Store 0xDEAD_BEEF to 0x44 after the above: hit, stall 0. A subsequent load 0x44 returns 0xDEAD_BEEF and dirty[2] = 1.
- Load 0x0000_0440 (same index 2, tag 1): WRITEBACK issues mem_addr_o = 0x40 with word1 = 0xDEAD_BEEF. REFILL then follows at 0x440 with no gap in mem_enable_o.
- Store miss to 0x0000_0080 (clean): refill, then the word is written. Load 0x80 returns the stored value and the line is dirty.
- Assert rst_i low during REFILL: mem_enable_o drops immediately. After reset, a load 0x40 misses again (valid cleared).
- Hold p1_req_i = 0 for 10 cycles in IDLE: p1_stall_o = 0 and mem_enable_o = 0 throughout.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int TAG_W  = 22;
    localparam int IDX_W  = 5;
    localparam int OFF_W  = 5;
    localparam int WSEL_W = 3;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        FILL      = 2'd3
    } state_t;

    // Tag field of a byte address.
    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[31:10];
    endfunction

    // Line index of a byte address.
    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        return addr[9:5];
    endfunction

    // Word-within-line select of a byte address.
    function automatic logic [WSEL_W-1:0] addr_word(input logic [31:0] addr);
        return addr[4:2];
    endfunction

    // Line-aligned byte address built from a tag and an index.
    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        return {tag, idx, 5'b00000};
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Valid/dirty/tag/data storage for the data cache: asynchronous read,
// synchronous full-line or single-word write, reset clears valid and dirty.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES  = 32,
    parameter int LINE_W = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic               rd_valid_o,
    output logic               rd_dirty_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [LINE_W-1:0]  rd_line_o,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic               line_we_i,
    input  logic [TAG_W-1:0]   line_tag_i,
    input  logic [LINE_W-1:0]  line_data_i,
    input  logic               word_we_i,
    input  logic [WSEL_W-1:0]  word_sel_i,
    input  logic [WORD_W-1:0]  word_data_i
);

    logic [LINES-1:0]  valid_r;
    logic [LINES-1:0]  dirty_r;
    logic [TAG_W-1:0]  tag_r  [LINES];
    logic [LINE_W-1:0] data_r [LINES];

    assign rd_valid_o = valid_r[rd_idx_i];
    assign rd_dirty_o = dirty_r[rd_idx_i];
    assign rd_tag_o   = tag_r[rd_idx_i];
    assign rd_line_o  = data_r[rd_idx_i];

    // Line state bits: a fill leaves the line clean, a word store marks it dirty.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if (line_we_i) begin
            valid_r[wr_idx_i] <= 1'b1;
            dirty_r[wr_idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_r[wr_idx_i] <= 1'b1;
        end else begin
            valid_r <= valid_r;
            dirty_r <= dirty_r;
        end
    end

    // Tag and data arrays are plain storage; validity alone gates their use.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_r[wr_idx_i]  <= line_tag_i;
            data_r[wr_idx_i] <= line_data_i;
        end else if (word_we_i) begin
            data_r[wr_idx_i][{word_sel_i, 5'b00000} +: WORD_W] <= word_data_i;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache between the MEM stage
// and off-chip memory. Hits answer in the same cycle; misses stall the
// pipeline while a dirty victim is written back and the line is refilled.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int LINES  = 32,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    state_t              state_r;
    logic [TAG_W-1:0]    miss_tag_r;
    logic [IDX_W-1:0]    miss_idx_r;
    logic [LINE_W-1:0]   line_buf_r;
    logic                mem_enable_r;
    logic                mem_write_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [LINE_W-1:0]   mem_data_r;

    logic [TAG_W-1:0]    req_tag_s;
    logic [IDX_W-1:0]    req_idx_s;
    logic [WSEL_W-1:0]   req_word_s;
    logic                sram_valid_s;
    logic                sram_dirty_s;
    logic [TAG_W-1:0]    sram_tag_s;
    logic [LINE_W-1:0]   sram_line_s;
    logic                hit_s;
    logic                line_we_s;
    logic                word_we_s;
    logic [IDX_W-1:0]    wr_idx_s;
    logic                unused_addr_s;

    assign req_tag_s     = addr_tag(p1_addr_i);
    assign req_idx_s     = addr_idx(p1_addr_i);
    assign req_word_s    = addr_word(p1_addr_i);
    assign unused_addr_s = ^p1_addr_i[1:0];

    assign hit_s     = sram_valid_s && (sram_tag_s == req_tag_s);
    assign line_we_s = (state_r == FILL);
    assign word_we_s = (state_r == IDLE) && p1_req_i && p1_write_i && hit_s;
    assign wr_idx_s  = (state_r == FILL) ? miss_idx_r : req_idx_s;

    dcache_sram #(
        .LINES  (LINES),
        .LINE_W (LINE_W)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (req_idx_s),
        .rd_valid_o  (sram_valid_s),
        .rd_dirty_o  (sram_dirty_s),
        .rd_tag_o    (sram_tag_s),
        .rd_line_o   (sram_line_s),
        .wr_idx_i    (wr_idx_s),
        .line_we_i   (line_we_s),
        .line_tag_i  (miss_tag_r),
        .line_data_i (line_buf_r),
        .word_we_i   (word_we_s),
        .word_sel_i  (req_word_s),
        .word_data_i (p1_data_i)
    );

    assign mem_enable_o = mem_enable_r;
    assign mem_write_o  = mem_write_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_data_o   = mem_data_r;

    // Pipeline-side response: same-cycle hit data, stall on miss or busy FSM.
    always_comb begin
        p1_data_o  = 32'h0000_0000;
        p1_stall_o = 1'b0;
        if (!rst_i) begin
            p1_data_o  = 32'h0000_0000;
            p1_stall_o = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (p1_req_i && hit_s) begin
                        p1_data_o  = sram_line_s[{req_word_s, 5'b00000} +: 32];
                        p1_stall_o = 1'b0;
                    end else if (p1_req_i) begin
                        p1_stall_o = 1'b1;
                    end else begin
                        p1_stall_o = 1'b0;
                    end
                end
                default: p1_stall_o = 1'b1;
            endcase
        end
    end

    // Miss sequencing and the registered memory-side request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= IDLE;
            miss_tag_r   <= '0;
            miss_idx_r   <= '0;
            line_buf_r   <= '0;
            mem_enable_r <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= '0;
            mem_data_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (p1_req_i && !hit_s) begin
                        miss_tag_r   <= req_tag_s;
                        miss_idx_r   <= req_idx_s;
                        mem_enable_r <= 1'b1;
                        if (sram_valid_s && sram_dirty_s) begin
                            state_r     <= WRITEBACK;
                            mem_write_r <= 1'b1;
                            mem_addr_r  <= line_addr(sram_tag_s, req_idx_s);
                            mem_data_r  <= sram_line_s;
                        end else begin
                            state_r     <= REFILL;
                            mem_write_r <= 1'b0;
                            mem_addr_r  <= line_addr(req_tag_s, req_idx_s);
                            mem_data_r  <= '0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WRITEBACK: begin
                    // Read request follows back-to-back; enable stays high.
                    if (mem_ack_i) begin
                        state_r     <= REFILL;
                        mem_write_r <= 1'b0;
                        mem_addr_r  <= line_addr(miss_tag_r, miss_idx_r);
                        mem_data_r  <= '0;
                    end else begin
                        state_r <= WRITEBACK;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state_r      <= FILL;
                        line_buf_r   <= mem_data_i;
                        mem_enable_r <= 1'b0;
                        mem_addr_r   <= '0;
                    end else begin
                        state_r <= REFILL;
                    end
                end
                FILL: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    mem_enable_r <= 1'b0;
                    mem_write_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized scoreboard bench for dcache_controller. A flat word-addressed
// memory is the golden model; a behavioural memory responder serves refills
// and absorbs write-backs.
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         p1_req;
    logic         p1_write;
    logic [31:0]  p1_addr;
    logic [31:0]  p1_wdata;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_rdata;
    logic         mem_ack;

    dcache_controller dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .p1_req_i     (p1_req),
        .p1_write_i   (p1_write),
        .p1_addr_i    (p1_addr),
        .p1_data_i    (p1_wdata),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_rdata),
        .mem_ack_i    (mem_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- models ----------------
    logic [31:0] bmem [int unsigned];   // backing memory contents
    logic [31:0] gold [int unsigned];   // what the CPU should observe
    bit          cvalid [32];
    bit          cdirty [32];
    logic [21:0] ctag   [32];

    function automatic logic [31:0] init_word(input int unsigned wa);
        return (wa * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] bget(input int unsigned wa);
        return bmem.exists(wa) ? bmem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] gget(input int unsigned wa);
        return gold.exists(wa) ? gold[wa] : init_word(wa);
    endfunction

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } xfer_t;
    xfer_t xlog[$];

    typedef struct {
        bit          is_load;
        logic [31:0] data;
        int          stall;
    } exp_t;
    exp_t sbq[$];

    int lat_cfg = 1;
    bit mon_en  = 1'b0;
    int stall_cnt = 0;
    int noen_cnt  = 0;

    // ---------------- memory responder ----------------
    initial begin
        int cnt;
        int unsigned wa;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!rst_n || !mem_enable_o) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= lat_cfg) begin
                    cnt     = 0;
                    mem_ack = 1'b1;
                    check("mem_addr_align", {27'd0, mem_addr_o[4:0]}, 32'd0);
                    wa = mem_addr_o >> 2;
                    if (mem_write_o) begin
                        for (int w = 0; w < 8; w++) bmem[wa + w] = mem_data_o[w*32 +: 32];
                    end else begin
                        for (int w = 0; w < 8; w++) mem_rdata[w*32 +: 32] = bget(wa + w);
                    end
                    xlog.push_back('{wr: mem_write_o, addr: mem_addr_o, data: mem_data_o});
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mon_en && p1_req) begin
            if (p1_stall_o) begin
                stall_cnt++;
                if (!mem_enable_o) noen_cnt++;
            end else begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got completion expected none");
                end else begin
                    e = sbq.pop_front();
                    check("stall_cycles", stall_cnt, e.stall);
                    if (e.stall > 0) check("mem_idle_cycles_in_miss", noen_cnt, 32'd2);
                    if (e.is_load) check("load_data", p1_data_o, e.data);
                end
                stall_cnt = 0;
                noen_cnt  = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_access(input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input int lat);
        int unsigned wa;
        int          idx;
        logic [21:0] tag;
        bit          hit;
        bit          done;
        exp_t        e;
        wa  = addr >> 2;
        idx = int'(addr[9:5]);
        tag = addr[31:10];
        hit = cvalid[idx] && (ctag[idx] == tag);
        if (hit) e.stall = 0;
        else if (cvalid[idx] && cdirty[idx]) e.stall = 2 + 2 * lat;
        else e.stall = 2 + lat;
        if (!hit) begin
            cvalid[idx] = 1'b1;
            ctag[idx]   = tag;
            cdirty[idx] = 1'b0;
        end
        if (wr) cdirty[idx] = 1'b1;
        e.is_load = !wr;
        e.data    = gget(wa);
        if (wr) gold[wa] = data;
        sbq.push_back(e);
        lat_cfg  = lat;
        p1_req   = 1'b1;
        p1_write = wr;
        p1_addr  = addr;
        p1_wdata = data;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!p1_stall_o) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL access_timeout: addr %h still stalled after 400 cycles", addr);
        end
        @(posedge clk);
        #1;
        p1_req   = 1'b0;
        p1_write = 1'b0;
    endtask

    task automatic clear_cache_model();
        for (int i = 0; i < 32; i++) begin
            cvalid[i] = 1'b0;
            cdirty[i] = 1'b0;
            ctag[i]   = '0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit          done;
        logic [31:0] addr;
        p1_req   = 1'b0;
        p1_write = 1'b0;
        p1_addr  = 32'h0;
        p1_wdata = 32'h0;
        rst_n    = 1'b0;
        clear_cache_model();
        bmem[32'h40 >> 2] = 32'h1111_1111;
        gold = bmem;

        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", {31'd0, p1_stall_o}, 32'd0);
        check("reset_mem_enable", {31'd0, mem_enable_o}, 32'd0);
        check("reset_mem_write", {31'd0, mem_write_o}, 32'd0);
        check("reset_mem_addr", mem_addr_o, 32'd0);
        check("reset_mem_data", {31'd0, |mem_data_o}, 32'd0);
        check("reset_p1_data", p1_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // clean load miss, 3-cycle memory latency -> 5 stall cycles
        xlog.delete();
        do_access(1'b0, 32'h0000_0040, 32'h0, 3);
        check("first_miss_xfers", xlog.size(), 32'd1);
        if (xlog.size() >= 1) begin
            check("first_miss_is_read", {31'd0, xlog[0].wr}, 32'd0);
            check("first_miss_addr", xlog[0].addr, 32'h40);
        end

        // store hit then load back
        do_access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 2);
        do_access(1'b0, 32'h0000_0044, 32'h0, 2);

        // conflicting tag: dirty victim write-back then refill
        xlog.delete();
        do_access(1'b0, 32'h0000_0440, 32'h0, 2);
        check("evict_xfers", xlog.size(), 32'd2);
        if (xlog.size() >= 2) begin
            check("wb_is_write", {31'd0, xlog[0].wr}, 32'd1);
            check("wb_addr", xlog[0].addr, 32'h40);
            check("wb_word1", xlog[0].data[63:32], 32'hDEAD_BEEF);
            check("refill_is_read", {31'd0, xlog[1].wr}, 32'd0);
            check("refill_addr", xlog[1].addr, 32'h440);
        end

        // clean store miss: allocate then write
        xlog.delete();
        do_access(1'b1, 32'h0000_0080, 32'hCAFE_F00D, 1);
        check("store_miss_xfers", xlog.size(), 32'd1);
        do_access(1'b0, 32'h0000_0080, 32'h0, 1);
        xlog.delete();
        do_access(1'b0, 32'h0000_0480, 32'h0, 1);
        if (xlog.size() >= 1) begin
            check("store_miss_dirty_wb", {31'd0, xlog[0].wr}, 32'd1);
            check("store_miss_wb_addr", xlog[0].addr, 32'h80);
            check("store_miss_wb_word0", xlog[0].data[31:0], 32'hCAFE_F00D);
        end else begin
            check("store_miss_dirty_wb_present", xlog.size(), 32'd1);
        end

        // reset in the middle of a refill
        mon_en   = 1'b0;
        lat_cfg  = 20;
        p1_req   = 1'b1;
        p1_write = 1'b0;
        p1_addr  = 32'h0000_0040;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (mem_enable_o) done = 1'b1;
        end
        check("abort_refill_started", {31'd0, done}, 32'd1);
        check("abort_refill_is_read", {31'd0, mem_write_o}, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_enable_drops", {31'd0, mem_enable_o}, 32'd0);
        check("abort_stall_low", {31'd0, p1_stall_o}, 32'd0);
        check("abort_addr_clear", mem_addr_o, 32'd0);
        p1_req = 1'b0;
        clear_cache_model();
        gold = bmem;
        xlog.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_access(1'b0, 32'h0000_0040, 32'h0, 2);
        check("post_reset_xfers", xlog.size(), 32'd1);
        if (xlog.size() >= 1) check("post_reset_refill_addr", xlog[0].addr, 32'h40);

        // idle: no request, no activity
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_stall", {31'd0, p1_stall_o}, 32'd0);
            check("idle_mem_enable", {31'd0, mem_enable_o}, 32'd0);
        end
        @(posedge clk);
        #1;

        // randomized traffic over a few conflicting tags
        for (int n = 0; n < 300; n++) begin
            addr = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 5)
                 | ($urandom_range(0, 7) << 2);
            do_access(1'($urandom_range(0, 1)), addr, $urandom, int'($urandom_range(1, 3)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
